// File: rtl/ifid_pipe_ctrl_pkg.sv
// Shared fetch/decode constants and the IF/ID bundle.
// Imported by the fetch control, its counters and the hazard unit.
package ifid_pipe_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Canonical bubble contents for the IF/ID register.
    function automatic if_id_t ifid_bubble(input logic [XLEN-1:0] nop);
        if_id_t b;
        b.pc       = '0;
        b.pc_plus4 = PC_INC;
        b.instr    = nop;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ifid_pipe_ctrl_sat_counter.sv
// Saturating event counter used for the stall and flush statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter
    import ifid_pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ifid_pipe_ctrl.sv
// Fetch PC and IF/ID pipeline register with flush/stall control.
// Flush beats stall beats advance; stall/flush events are counted.
module ifid_pipe_ctrl
    import ifid_pipe_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ID_pc,
    output logic [XLEN-1:0] ID_pc_plus4,
    output logic [XLEN-1:0] ID_instr,
    output logic            ID_valid,
    output logic            EX_bubble,
    output logic [XLEN-1:0] stall_count,
    output logic [XLEN-1:0] flush_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    if_id_t          ifid_q;
    if_id_t          ifid_d;
    logic            stall_inc;
    logic            flush_inc;

    // Select exactly one action per edge: redirect, hold, or advance.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (flush) begin
            pc_d   = {redirect_target[XLEN-1:2], 2'b00};
            ifid_d = ifid_bubble(NOP_INSTR);
        end else if (!stall) begin
            pc_d            = pc_q + PC_INC;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus4 = pc_q + PC_INC;
            ifid_d.instr    = imem_instr;
            ifid_d.valid    = 1'b1;
        end
    end

    // PC and IF/ID state; reset loads the start PC and a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= ifid_bubble(NOP_INSTR);
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    // A flush that coincides with a stall counts only as a flush.
    always_comb begin
        stall_inc = stall & ~flush;
        flush_inc = flush;
    end

    sat_counter #(.W(XLEN)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(XLEN)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign pc_out      = pc_q;
    assign ID_pc       = ifid_q.pc;
    assign ID_pc_plus4 = ifid_q.pc_plus4;
    assign ID_instr    = ifid_q.instr;
    assign ID_valid    = ifid_q.valid;
    assign EX_bubble   = stall | flush;

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Scoreboard bench for ifid_pipe_ctrl: directed steps push expected
// snapshots, a monitor pops them after each edge or reset probe.
module tb_ifid_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_target;
    logic [31:0] imem_instr;
    logic [31:0] pc_out;
    logic [31:0] ID_pc;
    logic [31:0] ID_pc_plus4;
    logic [31:0] ID_instr;
    logic        ID_valid;
    logic        EX_bubble;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic [31:0] ins;
        logic        vld;
        logic        bub;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tagn  = 0;
    event probe_ev;

    ifid_pipe_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect_target (redirect_target),
        .imem_instr      (imem_instr),
        .pc_out          (pc_out),
        .ID_pc           (ID_pc),
        .ID_pc_plus4     (ID_pc_plus4),
        .ID_instr        (ID_instr),
        .ID_valid        (ID_valid),
        .EX_bubble       (EX_bubble),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at PC reads as A0+PC.
    assign imem_instr = 32'h0000_00A0 + pc_out;

    task automatic chk(input string nm, input int tg,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step%0d actual=%h required=%h", nm, tg, act, req);
        end
    endtask

    // Monitor: compare after every edge and after async reset probes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or probe_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out",      e.tag, pc_out,      e.pc);
                chk("ID_pc",       e.tag, ID_pc,       e.ipc);
                chk("ID_pc_plus4", e.tag, ID_pc_plus4, e.ip4);
                chk("ID_instr",    e.tag, ID_instr,    e.ins);
                chk("ID_valid",    e.tag, {31'd0, ID_valid},  {31'd0, e.vld});
                chk("EX_bubble",   e.tag, {31'd0, EX_bubble}, {31'd0, e.bub});
                chk("stall_count", e.tag, stall_count, e.sc);
                chk("flush_count", e.tag, flush_count, e.fc);
            end
        end
    end

    task automatic push(input logic [31:0] pc, ipc, ip4, ins,
                        input logic v, b, input logic [31:0] sc, fc);
        exp_t e;
        e.tag = tagn;
        e.pc  = pc;
        e.ipc = ipc;
        e.ip4 = ip4;
        e.ins = ins;
        e.vld = v;
        e.bub = b;
        e.sc  = sc;
        e.fc  = fc;
        q.push_back(e);
        tagn++;
    endtask

    // One clocked step: drive inputs, queue state expected after the edge.
    task automatic step(input logic s, f, input logic [31:0] t,
                        input logic [31:0] pc, ipc, ip4, ins,
                        input logic v, input logic [31:0] sc, fc);
        @(negedge clk);
        reset           = 1'b0;
        stall           = s;
        flush           = f;
        redirect_target = t;
        push(pc, ipc, ip4, ins, v, s | f, sc, fc);
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_target = 32'h0;

        // Reset state held across an edge.
        @(negedge clk);
        push(32'h0, 32'h0, 32'h4, 32'h13, 1'b0, 1'b0, 32'd0, 32'd0);

        // Advance from reset: pc 4, 8; ID sees A0, A4.
        step(0, 0, 32'h0, 32'h4, 32'h0, 32'h4, 32'hA0, 1, 0, 0);
        step(0, 0, 32'h0, 32'h8, 32'h4, 32'h8, 32'hA4, 1, 0, 0);
        // Two-cycle stall at pc 8.
        step(1, 0, 32'h0, 32'h8, 32'h4, 32'h8, 32'hA4, 1, 1, 0);
        step(1, 0, 32'h0, 32'h8, 32'h4, 32'h8, 32'hA4, 1, 2, 0);
        // First edge after stall advances.
        step(0, 0, 32'h0, 32'hC, 32'h8, 32'hC, 32'hA8, 1, 2, 0);
        // Flush to 0x103 -> aligned 0x100.
        step(0, 1, 32'h103, 32'h100, 32'h0, 32'h4, 32'h13, 0, 2, 1);
        // Stall+flush together: flush wins, only flush_count moves.
        step(1, 1, 32'h40, 32'h40, 32'h0, 32'h4, 32'h13, 0, 2, 2);
        // Back-to-back flush to top of address space.
        step(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h13, 0, 2, 3);
        // Advance wraps pc and pc_plus4 to 0.
        step(0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h9C, 1, 2, 3);
        step(0, 0, 32'h0, 32'h4, 32'h0, 32'h4, 32'hA0, 1, 2, 3);
        // Stall, then reset arrives mid-cycle while stalled.
        step(1, 0, 32'h0, 32'h4, 32'h0, 32'h4, 32'hA0, 1, 3, 3);
        step(1, 0, 32'h0, 32'h4, 32'h0, 32'h4, 32'hA0, 1, 4, 3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        push(32'h0, 32'h0, 32'h4, 32'h13, 1'b0, 1'b1, 32'd0, 32'd0);
        -> probe_ev;
        // Release reset with stall dropped: first edge advances.
        step(0, 0, 32'h0, 32'h4, 32'h0, 32'h4, 32'hA0, 1, 0, 0);
        step(0, 0, 32'h0, 32'h8, 32'h4, 32'h8, 32'hA4, 1, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_ctrl.md
IFID_PIPE_CTRL -- requirements
Module: ifid_pipe_ctrl

Interface
REQ-001 The module SHALL have exactly one clock domain; reset is asynchronous and active-high. Ports `clk` and `reset`.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter: NOP_INSTR, default 32'h0000_0013, the `addi x0,x0,0` instruction inserted as a bubble.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous active-high reset.
- stall, input, 1: load-use stall request from hazard detection.
- flush, input, 1: taken-branch/jump flush request.
- redirect_target, input, 32: new PC, sampled when flush=1.
- imem_instr, input, 32: instruction read combinationally at pc_out.
- pc_out, output, 32: current fetch PC (instruction-memory address).
- ID_pc, output, 32: PC of the instruction in the IF/ID register.
- ID_pc_plus4, output, 32: ID_pc+4.
- ID_instr, output, 32: instruction in the IF/ID register.
- ID_valid, output, 1: 1 if ID_instr is a real instruction, 0 if it is a bubble.
- EX_bubble, output, 1: combinational request to zero the ID/EX control signals this cycle.
- stall_count, output, 32: number of stall cycles, saturating.
- flush_count, output, 32: number of flush cycles, saturating.

Function
REQ-005 Each rising clock edge SHALL take exactly one action, in priority order: flush, then stall, then advance.
REQ-006 Flush (flush=1, regardless of stall):
- pc_out <= {redirect_target[31:2], 2'b00}.
- ID_instr <= NOP_INSTR, ID_valid <= 0.
- ID_pc <= 0, ID_pc_plus4 <= 4.
REQ-007 Stall (stall=1, flush=0): pc_out and every IF/ID output SHALL hold their values.
REQ-008 Advance (stall=0, flush=0):
- ID_pc <= pc_out, ID_pc_plus4 <= pc_out+4.
- ID_instr <= imem_instr, ID_valid <= 1.
- pc_out <= pc_out+4.
REQ-009 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
REQ-010 Latency: an instruction fetched at pc_out in cycle N SHALL appear on ID_instr in cycle N+1 when it advances.
REQ-011 EX_bubble SHALL equal stall | flush, combinationally, with no register.
REQ-012 stall_count SHALL increment on each edge where stall=1 and flush=0, and saturate at 32'hFFFF_FFFF.
REQ-013 flush_count SHALL increment on each edge where flush=1, and saturate at 32'hFFFF_FFFF.
REQ-014 When stall and flush are both 1 on the same edge, only flush_count SHALL increment.
REQ-015 A stall held for K consecutive cycles SHALL hold the PC and IF/ID for exactly K edges; the first edge after stall falls SHALL advance.
REQ-016 Back-to-back flushes SHALL each redirect to the redirect_target value current on that edge, and ID_valid SHALL stay 0.
REQ-017 Outputs SHALL never be X after reset, even if imem_instr is X while ID_valid=0.

Reset
REQ-018 While reset=1, the following SHALL be forced immediately (asynchronously), with no clock required:
- pc_out = RESET_PC.
- ID_pc = 0, ID_pc_plus4 = 4.
- ID_instr = NOP_INSTR, ID_valid = 0.
- stall_count = 0, flush_count = 0.
REQ-019 Reset asserted mid-stall or mid-flush SHALL discard the pending action. The first edge after reset deasserts SHALL follow REQ-005 using the current inputs.

Structure
REQ-020 A shared package SHALL hold XLEN=32, NOP_INSTR, RESET_PC, and the PC increment constant 4; the CPU top and the hazard unit import the same package.
REQ-021 One sub-module, `sat_counter`, SHALL provide a 32-bit saturating counter with inputs clk, reset and inc. It SHALL be instantiated twice, once for stall_count and once for flush_count.
REQ-022 The PC register and the IF/ID register SHALL live in this module, and no other module SHALL write them.

Verification
REQ-023 Reset release with no stall or flush, imem returning 32'hA0+PC: pc_out sequence 0,4,8; ID_instr reads A0,A4 from cycle 1; ID_valid is 1 from cycle 1.
REQ-024 Stall for 2 cycles at PC=8: pc_out stays 8 and ID_pc stays 4 for 2 edges; stall_count=2; EX_bubble is high for both cycles.
REQ-025 Flush with redirect_target=32'h0000_0103: pc_out=32'h100, ID_instr=32'h13, ID_valid=0, flush_count=1.
REQ-026 Stall and flush together with redirect_target=32'h40: pc_out=32'h40, stall_count unchanged, flush_count increments by 1.
REQ-027 Set pc_out to 32'hFFFF_FFFC via a flush, then advance: pc_out=0 and ID_pc_plus4=0.
REQ-028 Assert reset asynchronously mid-cycle during a stall: all outputs take their REQ-018 values before the next edge, and the counters read 0.
